// File: rtl/lfsr_seq_ctrl.sv
// Command-driven Fibonacci LFSR sequencer: LOAD/RUN commands in, stepped LFSR value out.
// Optional build macro LFSR_ZERO_GUARD_EN: a zero LOAD seed is replaced by 1.
module lfsr_seq_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'h1D,
    parameter logic [WIDTH-1:0] SEED_RST = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             zero_lock
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN  = 2'b10;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] count;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {^(v & TAPS), v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] seed_value(input logic [WIDTH-1:0] d);
`ifdef LFSR_ZERO_GUARD_EN
        return (d == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : d;
`else
        return d;
`endif
    endfunction

    // cmd_ready/busy/out_valid are registered alongside the state so that they
    // are all low while reset is held and change only on clock edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= SEED_RST;
            count     <= '0;
            cmd_ready <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        case (cmd_op)
                            OP_LOAD: lfsr <= seed_value(cmd_data);
                            OP_RUN: begin
                                count     <= cmd_data;
                                state     <= RUN;
                                cmd_ready <= 1'b0;
                                busy      <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Abort wins over a step: the edge that sees abort does not advance.
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else if (count != '0) begin
                        lfsr  <= lfsr_step(lfsr);
                        count <= count - 1'b1;
                    end else begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = lfsr;
    assign zero_lock = (lfsr == '0);

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed scenarios plus randomized command
// sequences checked against a bit-counting reference model.
module tb_lfsr_seq_ctrl;

    localparam logic [7:0] TAPS = 8'h1D;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       zero_lock;

    int passed = 0;
    int total  = 0;
    logic [7:0] model;

    lfsr_seq_ctrl dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .zero_lock(zero_lock)
    );

    always #5 clk = ~clk;

    // Reference: parity of tapped bits by counting ones, value halved, parity added as MSB.
    function automatic logic [7:0] ref_step(input logic [7:0] v);
        int ones;
        logic [7:0] r;
        logic [7:0] t;
        ones = 0;
        t = TAPS;
        for (int i = 0; i < 8; i++) if (v[i] && t[i]) ones++;
        r = v / 8'd2;
        if (ones % 2 == 1) r = r + 8'd128;
        return r;
    endfunction

    function automatic logic [7:0] ref_run(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = ref_step(r);
        return r;
    endfunction

    function automatic logic [7:0] ref_load(input logic [7:0] d);
`ifdef LFSR_ZERO_GUARD_EN
        return (d == 8'd0) ? 8'd1 : d;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
        int guard;
        guard = 0;
        while (!cmd_ready) begin
            tick();
            guard++;
            if (guard > 1000) begin
                $display("FAIL send_cmd: cmd_ready stayed %b, required 1", cmd_ready);
                $fatal(1, "command port stuck");
            end
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 2000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        abort = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready_in_reset: got %b want 0", cmd_ready); else passed++;
        reset = 1'b0;
        repeat (2) tick();
        model = 8'h01;
        total++; if (out_data !== 8'h01) $display("FAIL reset_out_data: got %h want 01", out_data); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
        total++; if (zero_lock !== 1'b0) $display("FAIL reset_zero_lock: got %b want 0", zero_lock); else passed++;
    endtask

    task automatic test_run_basic();
        int cyc;
        send_cmd(2'b01, 8'h01);
        total++; if (out_data !== 8'h01) $display("FAIL load_value: got %h want 01", out_data); else passed++;
        send_cmd(2'b10, 8'd4);
        total++; if (busy !== 1'b1) $display("FAIL run_busy: got %b want 1", busy); else passed++;
        wait_valid(cyc);
        total++; if (cyc !== 5) $display("FAIL run4_latency: got %0d want 5", cyc); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 8'h10)
                $display("FAIL run4_hold: valid %b data %h want 1/10", out_valid, out_data); else passed++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL run4_release: valid %b busy %b want 0/0", out_valid, busy); else passed++;
        model = 8'h10;
    endtask

    task automatic test_run_zero();
        int cyc;
        send_cmd(2'b01, 8'h01);
        send_cmd(2'b10, 8'd5);
        wait_valid(cyc);
        total++; if (out_data !== 8'h88) $display("FAIL run5_value: got %h want 88", out_data); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send_cmd(2'b10, 8'd0);
        wait_valid(cyc);
        total++; if (cyc !== 1) $display("FAIL run0_latency: got %0d want 1", cyc); else passed++;
        total++; if (out_data !== 8'h88) $display("FAIL run0_value: got %h want 88", out_data); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        model = 8'h88;
    endtask

    task automatic test_abort_run();
        send_cmd(2'b01, 8'h01);
        send_cmd(2'b10, 8'd200);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_run_busy: got %b want 0", busy); else passed++;
        total++; if (out_data !== 8'h20) $display("FAIL abort_run_value: got %h want 20", out_data); else passed++;
        repeat (4) tick();
        total++; if (out_valid !== 1'b0) $display("FAIL abort_run_no_output: got %b want 0", out_valid); else passed++;
        model = 8'h20;
    endtask

    task automatic test_abort_out();
        int cyc;
        int delivered;
        send_cmd(2'b01, 8'h01);
        send_cmd(2'b10, 8'd6);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'h55;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            total++; if (cmd_ready !== 1'b0) $display("FAIL blocked_in_run: cmd_ready %b want 0", cmd_ready); else passed++;
            tick();
            cyc++;
        end
        total++; if (cmd_ready !== 1'b0) $display("FAIL blocked_in_out: cmd_ready %b want 0", cmd_ready); else passed++;
        cmd_valid = 1'b0;
        delivered = 0;
        abort = 1'b1; out_ready = 1'b1;
        if (out_valid) delivered++;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        model = ref_run(8'h01, 6);
        total++; if (delivered !== 1) $display("FAIL abort_ready_transfer: got %0d transfers want 1", delivered); else passed++;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_ready_idle: valid %b busy %b want 0/0", out_valid, busy); else passed++;
        total++; if (out_data !== model) $display("FAIL abort_ready_value: got %h want %h", out_data, model); else passed++;
        send_cmd(2'b10, 8'd2);
        wait_valid(cyc);
        abort = 1'b1; tick(); abort = 1'b0;
        model = ref_run(model, 2);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_out_drop: valid %b busy %b want 0/0", out_valid, busy); else passed++;
        total++; if (out_data !== model) $display("FAIL abort_out_value: got %h want %h", out_data, model); else passed++;
    endtask

    task automatic test_zero_seed();
        int cyc;
        logic [7:0] exp_v;
        send_cmd(2'b01, 8'h00);
        exp_v = ref_load(8'h00);
        total++; if (out_data !== exp_v) $display("FAIL zero_load: got %h want %h", out_data, exp_v); else passed++;
        total++; if (zero_lock !== (exp_v == 8'h00)) $display("FAIL zero_lock: got %b want %b", zero_lock, exp_v == 8'h00); else passed++;
        send_cmd(2'b10, 8'd7);
        wait_valid(cyc);
        exp_v = ref_run(exp_v, 7);
        total++; if (cyc !== 8) $display("FAIL zero_run7_latency: got %0d want 8", cyc); else passed++;
        total++; if (out_data !== exp_v) $display("FAIL zero_run7_value: got %h want %h", out_data, exp_v); else passed++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        model = exp_v;
    endtask

    task automatic test_random();
        int cyc;
        int n;
        int k;
        int stall;
        logic [1:0] op;
        logic [7:0] d;
        for (int it = 0; it < 40; it++) begin
            op = 2'($urandom_range(0, 3));
            d  = 8'($urandom);
            if (op == 2'b01 && $urandom_range(0, 4) == 0) d = 8'h00;
            if (op == 2'b10) d = 8'($urandom_range(0, 24));
            send_cmd(op, d);
            if (op == 2'b01) model = ref_load(d);
            if (op == 2'b10) begin
                n = int'(d);
                if (n > 2 && $urandom_range(0, 3) == 0) begin
                    k = $urandom_range(1, n);
                    repeat (k - 1) tick();
                    abort = 1'b1; tick(); abort = 1'b0;
                    model = ref_run(model, k - 1);
                    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== model)
                        $display("FAIL rnd_abort it%0d: v%b b%b d%h want 0/0/%h", it, out_valid, busy, out_data, model); else passed++;
                end else begin
                    wait_valid(cyc);
                    model = ref_run(model, n);
                    total++; if (cyc !== n + 1) $display("FAIL rnd_latency it%0d: got %0d want %0d", it, cyc, n + 1); else passed++;
                    stall = $urandom_range(0, 3);
                    repeat (stall) tick();
                    total++; if (out_valid !== 1'b1 || out_data !== model)
                        $display("FAIL rnd_result it%0d: v%b d%h want 1/%h", it, out_valid, out_data, model); else passed++;
                    out_ready = 1'b1; tick(); out_ready = 1'b0;
                end
            end else begin
                total++; if (out_data !== model || busy !== 1'b0)
                    $display("FAIL rnd_idle_cmd it%0d: d%h b%b want %h/0", it, out_data, busy, model); else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_basic();
        test_run_zero();
        test_abort_run();
        test_abort_out();
        test_zero_seed();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
